// File: rtl/s3_cse_forney_pkg.sv
// Shared GF(2^8) constants, FSM encoding and arithmetic helpers for the Chien search / Forney block.
package s3_cse_forney_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam logic [7:0] GF_ALPHA = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } cse_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // alpha^k for any signed k; elaboration-time use only.
  function automatic logic [7:0] alpha_pow(input int k);
    int         e;
    logic [7:0] r;
    e = k % 255;
    if (e < 0) e = e + 255;
    r = 8'h01;
    for (int i = 0; i < 255; i++) begin
      if (i < e) r = gf_mul(r, GF_ALPHA);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2m8_inverse.sv
// Combinational GF(2^8) inverse over the 0x11D field (inverse of 0 is 0).
module gf2m8_inverse
  import s3_cse_forney_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] z_o
);

  assign z_o = gf_inv(a_i);

endmodule

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier over the 0x11D field.
module gf2m8_multi
  import s3_cse_forney_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] z_o
);

  assign z_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/s3_cse_const_mul.sv
// Multiply by the elaboration-time constant alpha^K (K may be negative).
module s3_cse_const_mul
  import s3_cse_forney_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [7:0] a_i,
  output logic [7:0] z_o
);

  localparam logic [7:0] C = alpha_pow(K);

  gf2m8_multi u_mul (
    .a_i(a_i),
    .b_i(C),
    .z_o(z_o)
  );

endmodule

// File: rtl/s3_cse_forney.sv
// Chien search plus Forney error evaluation for up to two errors, scanning positions N-1..0.
// Optional root counter / decode-failure flag enabled by defining S3_CSE_ERRCNT_EN.
module s3_cse_forney
  import s3_cse_forney_pkg::*;
#(
  parameter int N = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       kes_done,
  input  logic [7:0] rs_lambda0,
  input  logic [7:0] rs_lambda1,
  input  logic [7:0] rs_lambda2,
  input  logic [7:0] rs_omega0,
  input  logic [7:0] rs_omega1,
  output logic       cse_busy,
  output logic       cse_valid,
  output logic [7:0] cse_pos,
  output logic [7:0] cse_eval,
  output logic       cse_done,
  output logic [1:0] err_cnt,
  output logic       uncorrectable,
  output cse_state_e dbg_state_o
);

  localparam logic [7:0] LAST_POS = 8'(N - 1);

  cse_state_e state_q, state_d;
  logic [7:0] lam0_q, lam1_q, lam2_q, om0_q, om1_q;
  logic [7:0] l1t_q, l2t_q, o0t_q;
  logic [7:0] j_q, pos_q, eval_q;
  logic       valid_q, done_q;
  logic [7:0] pre_l1, pre_l2, pre_o0, stp_l1, stp_l2, stp_o0;
  logic [7:0] sum_c, num_c, lam1_inv, quot_c, eval_c;
  logic       root_c;

  s3_cse_const_mul #(.K(-(N - 1)))     u_pre_l1 (.a_i(lam1_q), .z_o(pre_l1));
  s3_cse_const_mul #(.K(-2 * (N - 1))) u_pre_l2 (.a_i(lam2_q), .z_o(pre_l2));
  s3_cse_const_mul #(.K(N - 1))        u_pre_o0 (.a_i(om0_q),  .z_o(pre_o0));
  s3_cse_const_mul #(.K(1))            u_stp_l1 (.a_i(l1t_q),  .z_o(stp_l1));
  s3_cse_const_mul #(.K(2))            u_stp_l2 (.a_i(l2t_q),  .z_o(stp_l2));
  s3_cse_const_mul #(.K(-1))           u_stp_o0 (.a_i(o0t_q),  .z_o(stp_o0));

  // Terms hold lambda_k*alpha^(-k*j) and omega0*alpha^j for the position j being scanned.
  assign sum_c  = lam0_q ^ l1t_q ^ l2t_q;
  assign root_c = (sum_c == 8'h00) && ((lam1_q | lam2_q) != 8'h00);
  assign num_c  = o0t_q ^ om1_q;

  gf2m8_inverse u_inv (.a_i(lam1_q), .z_o(lam1_inv));
  gf2m8_multi   u_div (.a_i(num_c), .b_i(lam1_inv), .z_o(quot_c));

  assign eval_c = (root_c && (lam1_q != 8'h00)) ? quot_c : 8'h00;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (kes_done) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SCAN;
      ST_SCAN: if (j_q == 8'h00) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      lam0_q  <= 8'h00;
      lam1_q  <= 8'h00;
      lam2_q  <= 8'h00;
      om0_q   <= 8'h00;
      om1_q   <= 8'h00;
      l1t_q   <= 8'h00;
      l2t_q   <= 8'h00;
      o0t_q   <= 8'h00;
      j_q     <= 8'h00;
      pos_q   <= 8'h00;
      eval_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == ST_SCAN);
      done_q  <= (state_q == ST_DONE);
      pos_q   <= (state_q == ST_SCAN) ? j_q : 8'h00;
      eval_q  <= (state_q == ST_SCAN) ? eval_c : 8'h00;
      case (state_q)
        ST_IDLE: if (kes_done) begin
          lam0_q <= rs_lambda0;
          lam1_q <= rs_lambda1;
          lam2_q <= rs_lambda2;
          om0_q  <= rs_omega0;
          om1_q  <= rs_omega1;
        end
        ST_LOAD: begin
          l1t_q <= pre_l1;
          l2t_q <= pre_l2;
          o0t_q <= pre_o0;
          j_q   <= LAST_POS;
        end
        ST_SCAN: begin
          l1t_q <= stp_l1;
          l2t_q <= stp_l2;
          o0t_q <= stp_o0;
          j_q   <= j_q - 8'h01;
        end
        default: ;
      endcase
    end
  end

  // cse_valid qualifies cse_pos/cse_eval for one cycle each; there is no backpressure.
  assign cse_busy    = (state_q != ST_IDLE);
  assign cse_valid   = valid_q;
  assign cse_pos     = pos_q;
  assign cse_eval    = eval_q;
  assign cse_done    = done_q;
  assign dbg_state_o = state_q;

`ifdef S3_CSE_ERRCNT_EN
  logic [1:0] cnt_q;
  logic       unc_q;
  logic [1:0] deg_c;

  assign deg_c = (lam2_q != 8'h00) ? 2'd2 : ((lam1_q != 8'h00) ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 2'd0;
      unc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          cnt_q <= 2'd0;
          unc_q <= 1'b0;
        end
        ST_SCAN: if (root_c && (cnt_q != 2'd3)) cnt_q <= cnt_q + 2'd1;
        ST_DONE: unc_q <= (cnt_q != deg_c) || ((lam2_q != 8'h00) && (lam1_q == 8'h00));
        default: ;
      endcase
    end
  end

  assign err_cnt       = cnt_q;
  assign uncorrectable = unc_q;
`else
  assign err_cnt       = 2'd0;
  assign uncorrectable = 1'b0;
`endif

endmodule

// File: tb/tb_s3_cse_forney.sv
// Scoreboard bench for s3_cse_forney: full-length (N=255) and shortened (N=36) instances.
module tb_s3_cse_forney;
  import s3_cse_forney_pkg::*;

  localparam int N0 = 255;
  localparam int N1 = 36;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       kes_done [2];
  logic [7:0] l0 [2], l1 [2], l2 [2], o0 [2], o1 [2];
  logic       busy [2], valid [2], done [2], unc [2];
  logic [7:0] pos [2], ev [2];
  logic [1:0] ecnt [2];
  cse_state_e dstate [2];

  int checks = 0;
  int passed = 0;

  logic [16:0] exp_q[$];
  logic [2:0]  sum_q[$];

  logic [7:0] exp_t [255];
  int         log_t [256];

  always #5 clk = ~clk;

  s3_cse_forney #(.N(N0)) u_dut (
    .clk(clk), .rstn(rstn), .kes_done(kes_done[0]),
    .rs_lambda0(l0[0]), .rs_lambda1(l1[0]), .rs_lambda2(l2[0]),
    .rs_omega0(o0[0]), .rs_omega1(o1[0]),
    .cse_busy(busy[0]), .cse_valid(valid[0]), .cse_pos(pos[0]), .cse_eval(ev[0]),
    .cse_done(done[0]), .err_cnt(ecnt[0]), .uncorrectable(unc[0]), .dbg_state_o(dstate[0])
  );

  s3_cse_forney #(.N(N1)) u_dut36 (
    .clk(clk), .rstn(rstn), .kes_done(kes_done[1]),
    .rs_lambda0(l0[1]), .rs_lambda1(l1[1]), .rs_lambda2(l2[1]),
    .rs_omega0(o0[1]), .rs_omega1(o1[1]),
    .cse_busy(busy[1]), .cse_valid(valid[1]), .cse_pos(pos[1]), .cse_eval(ev[1]),
    .cse_done(done[1]), .err_cnt(ecnt[1]), .uncorrectable(unc[1]), .dbg_state_o(dstate[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s: unexpected DUT output (t=%0t)", name, $time);
  endtask

  // Reference field arithmetic via exp/log tables.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[int'(a)] + log_t[int'(b)]) % 255];
  endfunction

  function automatic logic [7:0] gdiv(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[int'(a)] - log_t[int'(b)] + 255) % 255];
  endfunction

  function automatic logic [7:0] apow(input int k);
    return exp_t[((k % 255) + 255) % 255];
  endfunction

  // Chien/Forney reference: evaluate Lambda and Omega directly at each X_j = alpha^j.
  task automatic model_push(input int inst, input int n, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] b0, input logic [7:0] b1);
    int roots, deg;
    logic [7:0] x, xj, lv, e;
    logic u;
    roots = 0;
    for (int j = n - 1; j >= 0; j--) begin
      x  = apow(-j);
      xj = apow(j);
      lv = a0 ^ gmul(a1, x) ^ gmul(a2, gmul(x, x));
      e  = 8'h00;
      if (lv == 8'h00 && (a1 != 8'h00 || a2 != 8'h00)) begin
        roots++;
        if (a1 != 8'h00) e = gdiv(gmul(xj, b0 ^ gmul(b1, x)), a1);
      end
      exp_q.push_back({inst[0], 8'(j), e});
    end
    if (roots > 3) roots = 3;
    deg = (a2 != 8'h00) ? 2 : ((a1 != 8'h00) ? 1 : 0);
    u = (roots != deg) || (a2 != 8'h00 && a1 == 8'h00);
`ifdef S3_CSE_ERRCNT_EN
    sum_q.push_back({2'(roots), u});
`else
    sum_q.push_back(3'b000);
`endif
  endtask

  // Build Lambda/Omega for up to two errors (b=0 convention).
  task automatic make_cw(input int ne, input int p1, input int p2, input logic [7:0] y1, input logic [7:0] y2,
                         output logic [7:0] a0, output logic [7:0] a1, output logic [7:0] a2,
                         output logic [7:0] b0, output logic [7:0] b1);
    logic [7:0] x1, x2;
    x1 = apow(p1);
    x2 = apow(p2);
    a0 = 8'h01; a1 = 8'h00; a2 = 8'h00; b0 = 8'h00; b1 = 8'h00;
    if (ne == 1) begin
      a1 = x1; b0 = y1;
    end else if (ne == 2) begin
      a1 = x1 ^ x2;
      a2 = gmul(x1, x2);
      b0 = y1 ^ y2;
      b1 = gmul(y1, x2) ^ gmul(y2, x1);
    end
  endtask

  task automatic pulse_kes(input int inst, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    l0[inst] = a0; l1[inst] = a1; l2[inst] = a2; o0[inst] = b0; o1[inst] = b1;
    kes_done[inst] = 1'b1;
    @(posedge clk);
    #1;
    kes_done[inst] = 1'b0;
    l0[inst] = 8'($urandom); l1[inst] = 8'($urandom); l2[inst] = 8'($urandom);
    o0[inst] = 8'($urandom); o1[inst] = 8'($urandom);
  endtask

  task automatic run_cw(input int inst, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] b0, input logic [7:0] b1, input int inject_at);
    int n, cyc;
    n = (inst == 0) ? N0 : N1;
    model_push(inst, n, a0, a1, a2, b0, b1);
    pulse_kes(inst, a0, a1, a2, b0, b1);
    @(negedge clk);
    check("busy_in_load", 32'(busy[inst]), 32'd1);
    check("valid_in_load", 32'(valid[inst]), 32'd0);
    @(negedge clk);
    check("valid_before_first", 32'(valid[inst]), 32'd0);
    @(negedge clk);
    check("valid_first", 32'(valid[inst]), 32'd1);
    cyc = 2;
    while (!done[inst] && cyc < n + 10) begin
      if (cyc == inject_at) begin
        kes_done[inst] = 1'b1;
        l0[inst] = 8'($urandom); l1[inst] = 8'($urandom); l2[inst] = 8'($urandom);
        o0[inst] = 8'($urandom); o1[inst] = 8'($urandom);
      end else begin
        kes_done[inst] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    kes_done[inst] = 1'b0;
    check("done_cycle", 32'(cyc), 32'(n + 2));
    check("busy_at_done", 32'(busy[inst]), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done[inst]), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    logic [2:0]  s;
    for (int i = 0; i < 2; i++) begin
      if (valid[i]) begin
        if (exp_q.size() == 0) note_fail("spurious_valid");
        else begin
          e = exp_q.pop_front();
          check("inst_pos_eval", {15'd0, i[0], pos[i], ev[i]}, {15'd0, e});
        end
      end
      if (done[i]) begin
        check("positions_drained", 32'(exp_q.size()), 32'd0);
        if (sum_q.size() == 0) note_fail("spurious_done");
        else begin
          s = sum_q.pop_front();
          check("err_cnt", 32'(ecnt[i]), 32'(s[2:1]));
          check("uncorrectable", 32'(unc[i]), 32'(s[0]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a0, a1, a2, b0, b1;
    logic [7:0] v;
    int inst, n, ne, p1, p2, quiet;
    logic [7:0] y1, y2;

    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[int'(v)] = i;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    end
    log_t[0] = 0;
    for (int i = 0; i < 2; i++) begin
      kes_done[i] = 1'b0;
      l0[i] = 8'($urandom); l1[i] = 8'($urandom); l2[i] = 8'($urandom);
      o0[i] = 8'($urandom); o1[i] = 8'($urandom);
    end

    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_valid", 32'(valid[i]), 32'd0);
      check("rst_pos", 32'(pos[i]), 32'd0);
      check("rst_eval", 32'(ev[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_err_cnt", 32'(ecnt[i]), 32'd0);
      check("rst_unc", 32'(unc[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_cw(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, -1);
    run_cw(0, 8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, -1);
    make_cw(2, 3, 200, 8'h11, 8'hC3, a0, a1, a2, b0, b1);
    run_cw(0, a0, a1, a2, b0, b1, -1);
    run_cw(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, -1);
    run_cw(1, 8'h01, apow(100), 8'h00, 8'($urandom), 8'($urandom), -1);
    run_cw(0, 8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, 50);

    // Abandon a codeword with reset in the middle of the scan.
    model_push(0, N0, 8'h01, 8'h74, 8'h00, 8'h5A, 8'h00);
    pulse_kes(0, 8'h01, 8'h74, 8'h00, 8'h5A, 8'h00);
    repeat (60) @(posedge clk);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    sum_q.delete();
    #1;
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_valid", 32'(valid[0]), 32'd0);
    check("midrst_pos_eval", {16'd0, pos[0], ev[0]}, 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    check("midrst_flags", {29'd0, ecnt[0], unc[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    quiet = 1;
    repeat (300) begin
      @(negedge clk);
      if (valid[0] || done[0] || busy[0]) quiet = 0;
    end
    check("quiet_after_reset", 32'(quiet), 32'd1);

    for (int t = 0; t < 8; t++) begin
      inst = int'($urandom_range(0, 1));
      n = (inst == 0) ? N0 : N1;
      if (t < 6) begin
        ne = int'($urandom_range(0, 2));
        p1 = int'($urandom_range(0, n - 1));
        do p2 = int'($urandom_range(0, n - 1)); while (p2 == p1);
        y1 = 8'($urandom_range(1, 255));
        y2 = 8'($urandom_range(1, 255));
        make_cw(ne, p1, p2, y1, y2, a0, a1, a2, b0, b1);
      end else begin
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        b0 = 8'($urandom); b1 = 8'($urandom);
      end
      run_cw(inst, a0, a1, a2, b0, b1, -1);
    end

    repeat (3) @(negedge clk);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_sum_q_empty", 32'(sum_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
